// File: rtl/spcpu_mem_arbiter_pkg.sv
// Types shared by the spcpu memory-port arbiter and its grant picker.
package pkg_mem_arb;

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} mem_arb_state;
  typedef enum logic [1:0] {DAT = 2'd0, IFT = 2'd1, DBG = 2'd2} mem_arb_req_id;

  localparam int mem_arb_num_req = 3;

  function automatic mem_arb_req_id other_cpu(input mem_arb_req_id id);
    return (id == DAT) ? IFT : DAT;
  endfunction

endpackage

// File: rtl/spcpu_mem_arbiter_picker.sv
// Combinational winner selection: DBG first unless it has hit its starvation cap,
// then round-robin between DAT and IFT.
module mem_arb_picker
  import pkg_mem_arb::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic [mem_arb_num_req-1:0] req,
  input  mem_arb_req_id              rr_ptr,
  input  logic [3:0]                 dbg_streak,
  output logic                       gnt_valid,
  output mem_arb_req_id              gnt_id
);

  logic cpu_pend;
  logic starved;

  always_comb begin
    cpu_pend  = req[DAT] | req[IFT];
    starved   = cpu_pend && (dbg_streak == 4'(STARVE_MAX));
    gnt_valid = |req;
    gnt_id    = DAT;
    if (req[DBG] && !starved) begin
      gnt_id = DBG;
    end else if (req[rr_ptr]) begin
      gnt_id = rr_ptr;
    end else if (req[other_cpu(rr_ptr)]) begin
      gnt_id = other_cpu(rr_ptr);
    end
  end

endmodule

// File: rtl/spcpu_mem_arbiter.sv
// Shares one memory port among DAT, IFT and DBG; one access per grant, MEM_LAT+1
// cycles from request to done, back-to-back grants re-arbitrated in the DONE cycle.
module spcpu_mem_arbiter
  import pkg_mem_arb::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [mem_arb_num_req-1:0]             req,
  input  logic [mem_arb_num_req-1:0][ADDR_W-1:0] addr,
  input  logic [mem_arb_num_req-1:0][DATA_W-1:0] wdata,
  input  logic [mem_arb_num_req-1:0]             we,
  input  logic [mem_arb_num_req-1:0]             acc_sz,
  output logic [mem_arb_num_req-1:0]             done,
  output logic [DATA_W-1:0]                      rdata,
  output logic [ADDR_W-1:0]                      mem_addr,
  output logic [DATA_W-1:0]                      mem_wdata,
  output logic                                   mem_we,
  output logic                                   mem_acc_sz,
  input  logic [DATA_W-1:0]                      mem_rdata,
  output logic                                   busy
);

  if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_mem_lat
    $error("spcpu_mem_arbiter: MEM_LAT must be in 1..7");
  end

  localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

  mem_arb_state                 state;
  mem_arb_req_id                gnt_q;
  mem_arb_req_id                rr_ptr;
  logic [3:0]                   dbg_streak;
  logic [2:0]                   lat_cnt;
  logic [mem_arb_num_req-1:0]   mask;
  logic [mem_arb_num_req-1:0]   req_eff;
  logic                         gnt_valid;
  mem_arb_req_id                gnt_id;
  logic                         start;
  logic                         cpu_pend;

  // The just-served CPU requester still shows req in its done cycle, so it is
  // masked; DBG is left visible so a held DBG request streams until the cap.
  always_comb begin
    mask = '0;
    if (state == DONE && gnt_q != DBG) mask[gnt_q] = 1'b1;
    req_eff  = req & ~mask;
    cpu_pend = req_eff[DAT] | req_eff[IFT];
    start    = gnt_valid && (state == IDLE || state == DONE);
  end

  mem_arb_picker #(.STARVE_MAX(STARVE_MAX)) u_picker (
    .req        (req_eff),
    .rr_ptr     (rr_ptr),
    .dbg_streak (dbg_streak),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      gnt_q      <= DAT;
      rr_ptr     <= DAT;
      dbg_streak <= '0;
      lat_cnt    <= '0;
      done       <= '0;
      rdata      <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      mem_acc_sz <= 1'b1;
      busy       <= 1'b0;
    end else begin
      done <= '0;
      if (start) begin
        state      <= ACCESS;
        gnt_q      <= gnt_id;
        mem_addr   <= addr[gnt_id];
        mem_wdata  <= wdata[gnt_id];
        mem_we     <= we[gnt_id];
        mem_acc_sz <= acc_sz[gnt_id];
        busy       <= 1'b1;
        lat_cnt    <= '0;
        if (gnt_id == DBG) begin
          dbg_streak <= cpu_pend ? ((dbg_streak == 4'hF) ? dbg_streak : dbg_streak + 4'd1) : 4'd0;
        end else begin
          rr_ptr     <= other_cpu(gnt_id);
          dbg_streak <= '0;
        end
      end else begin
        case (state)
          ACCESS: begin
            lat_cnt <= lat_cnt + 3'd1;
            if (lat_cnt == LAT_LAST) begin
              if (mem_we)          rdata <= '0;
              else if (mem_acc_sz) rdata <= mem_rdata;
              else                 rdata <= {{(DATA_W-8){1'b0}}, mem_rdata[7:0]};
              done   <= 3'b001 << gnt_q;
              mem_we <= 1'b0;
              busy   <= 1'b0;
              state  <= DONE;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  a_req_held: assert property (@(posedge clk) disable iff (reset) (state == ACCESS) |-> req[gnt_q]);

endmodule

// File: tb/tb_spcpu_mem_arbiter.sv
// Directed and randomized checks of spcpu_mem_arbiter (MEM_LAT=1 and MEM_LAT=3 instances).
module tb_spcpu_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, reset3;
  logic [2:0]       req, req3;
  logic [2:0][15:0] addr, wdata;
  logic [2:0]       we, acc_sz;
  logic [2:0]       done, done3;
  logic [15:0]      rdata, rdata3, mem_addr, mem_addr3, mem_wdata, mem_wdata3;
  logic             mem_we, mem_we3, mem_acc_sz, mem_acc_sz3, busy, busy3;
  logic [15:0]      mem_rdata, fixed_rdata;
  logic             use_model, model_init;
  logic [15:0]      model_mem [16];
  logic [15:0]      ref_mem [16];

  int compared = 0;
  int mismatched = 0;

  spcpu_mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset), .req(req), .addr(addr), .wdata(wdata), .we(we), .acc_sz(acc_sz),
    .done(done), .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_acc_sz(mem_acc_sz), .mem_rdata(mem_rdata), .busy(busy)
  );

  spcpu_mem_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) dut3 (
    .clk(clk), .reset(reset3), .req(req3), .addr(addr), .wdata(wdata), .we(we), .acc_sz(acc_sz),
    .done(done3), .rdata(rdata3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_we(mem_we3),
    .mem_acc_sz(mem_acc_sz3), .mem_rdata(mem_rdata), .busy(busy3)
  );

  function automatic logic [15:0] init_val(input int i);
    return 16'(i * 16'h1357) ^ 16'h5A5A;
  endfunction

  assign mem_rdata = use_model ? model_mem[mem_addr[3:0]] : fixed_rdata;

  always @(posedge clk) begin
    if (model_init) begin
      for (int i = 0; i < 16; i++) model_mem[i] <= init_val(i);
    end else if (use_model && mem_we) begin
      model_mem[mem_addr[3:0]] <= mem_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; reset3 = 1'b1; tick(); tick();
    compared++; if (done !== 3'b000) begin mismatched++; $display("FAIL rst_done: got %b required 000", done); end
    compared++; if (rdata !== 16'h0) begin mismatched++; $display("FAIL rst_rdata: got %h required 0000", rdata); end
    compared++; if (mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin mismatched++; $display("FAIL rst_mem_bus: got addr %h wdata %h required 0000/0000", mem_addr, mem_wdata); end
    compared++; if (mem_we !== 1'b0) begin mismatched++; $display("FAIL rst_mem_we: got %b required 0", mem_we); end
    compared++; if (mem_acc_sz !== 1'b1) begin mismatched++; $display("FAIL rst_acc_sz: got %b required 1", mem_acc_sz); end
    compared++; if (busy !== 1'b0 || busy3 !== 1'b0) begin mismatched++; $display("FAIL rst_busy: got %b/%b required 0/0", busy, busy3); end
    compared++; if (done3 !== 3'b000 || mem_acc_sz3 !== 1'b1) begin mismatched++; $display("FAIL rst_dut3: got done %b acc_sz %b required 000/1", done3, mem_acc_sz3); end
    reset = 1'b0; reset3 = 1'b0;
  endtask

  task automatic test_single_read();
    fixed_rdata = 16'hA55A;
    addr[1] = 16'h0010; we[1] = 1'b0; acc_sz[1] = 1'b1; req = 3'b010;
    tick();
    compared++; if (busy !== 1'b1 || mem_addr !== 16'h0010) begin mismatched++; $display("FAIL ift_access: got busy %b addr %h required 1/0010", busy, mem_addr); end
    compared++; if (done !== 3'b000) begin mismatched++; $display("FAIL ift_early_done: got %b required 000", done); end
    tick();
    compared++; if (done !== 3'b010) begin mismatched++; $display("FAIL ift_done: got %b required 010", done); end
    compared++; if (rdata !== 16'hA55A) begin mismatched++; $display("FAIL ift_rdata: got %h required a55a", rdata); end
    req = 3'b000;
    tick();
    compared++; if (done !== 3'b000 || busy !== 1'b0) begin mismatched++; $display("FAIL ift_idle: got done %b busy %b required 000/0", done, busy); end
  endtask

  task automatic test_byte_and_write();
    fixed_rdata = 16'h12F3;
    addr[0] = 16'h0021; we[0] = 1'b0; acc_sz[0] = 1'b0; req = 3'b001;
    tick();
    compared++; if (mem_acc_sz !== 1'b0 || mem_we !== 1'b0) begin mismatched++; $display("FAIL byte_bus: got acc_sz %b we %b required 0/0", mem_acc_sz, mem_we); end
    tick();
    compared++; if (done !== 3'b001 || rdata !== 16'h00F3) begin mismatched++; $display("FAIL byte_rdata: got done %b rdata %h required 001/00f3", done, rdata); end
    req = 3'b000;
    tick();
    addr[0] = 16'h0040; wdata[0] = 16'hBEEF; we[0] = 1'b1; acc_sz[0] = 1'b1; req = 3'b001;
    tick();
    compared++; if (mem_we !== 1'b1 || mem_wdata !== 16'hBEEF || mem_addr !== 16'h0040) begin mismatched++; $display("FAIL wr_bus: got we %b wdata %h addr %h required 1/beef/0040", mem_we, mem_wdata, mem_addr); end
    tick();
    compared++; if (done !== 3'b001 || rdata !== 16'h0000) begin mismatched++; $display("FAIL wr_done: got done %b rdata %h required 001/0000", done, rdata); end
    compared++; if (mem_we !== 1'b0) begin mismatched++; $display("FAIL wr_we_len: got mem_we %b in done cycle required 0", mem_we); end
    req = 3'b000; we[0] = 1'b0;
    tick();
    compared++; if (mem_we !== 1'b0) begin mismatched++; $display("FAIL wr_we_after: got %b required 0", mem_we); end
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_done;
    logic [15:0] exp_addr;
    reset = 1'b1; tick(); reset = 1'b0;
    fixed_rdata = 16'h3C3C;
    addr[0] = 16'h0100; addr[1] = 16'h0200; we = 3'b000; acc_sz = 3'b111; req = 3'b011;
    for (int k = 0; k < 4; k++) begin
      exp_done = (k % 2 == 0) ? 3'b001 : 3'b010;
      exp_addr = (k % 2 == 0) ? 16'h0100 : 16'h0200;
      tick();
      compared++; if (done !== 3'b000 || mem_addr !== exp_addr) begin mismatched++; $display("FAIL rr_access%0d: got done %b addr %h required 000/%h", k, done, mem_addr, exp_addr); end
      tick();
      compared++; if (done !== exp_done) begin mismatched++; $display("FAIL rr_order%0d: got %b required %b", k, done, exp_done); end
    end
    req = 3'b000;
    tick(); tick();
  endtask

  task automatic test_dbg_starve();
    logic [2:0] exp_seq [6];
    exp_seq = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b010, 3'b100};
    reset = 1'b1; tick(); reset = 1'b0;
    addr[1] = 16'h0300; addr[2] = 16'h0400; we = 3'b000; acc_sz = 3'b111; req = 3'b110;
    for (int k = 0; k < 6; k++) begin
      tick();
      compared++; if (done !== 3'b000) begin mismatched++; $display("FAIL dbg_gap%0d: got %b required 000", k, done); end
      tick();
      compared++; if (done !== exp_seq[k]) begin mismatched++; $display("FAIL dbg_order%0d: got %b required %b", k, done, exp_seq[k]); end
      if (done[1]) req[1] = 1'b0;
    end
    req = 3'b000;
    tick(); tick();
  endtask

  task automatic test_reset_mid_access();
    logic seen;
    addr[0] = 16'h0050; wdata[0] = 16'h1234; we[0] = 1'b1; acc_sz[0] = 1'b1; req3 = 3'b001;
    tick();
    compared++; if (mem_we3 !== 1'b1 || busy3 !== 1'b1 || mem_wdata3 !== 16'h1234 || mem_addr3 !== 16'h0050) begin mismatched++; $display("FAIL rm_access: got we %b busy %b wdata %h addr %h required 1/1/1234/0050", mem_we3, busy3, mem_wdata3, mem_addr3); end
    tick();
    compared++; if (mem_we3 !== 1'b1) begin mismatched++; $display("FAIL rm_we_hold: got %b required 1", mem_we3); end
    reset3 = 1'b1; req3 = 3'b000;
    tick();
    compared++; if (mem_we3 !== 1'b0 || busy3 !== 1'b0 || done3 !== 3'b000) begin mismatched++; $display("FAIL rm_reset: got we %b busy %b done %b required 0/0/000", mem_we3, busy3, done3); end
    reset3 = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done3 !== 3'b000 || busy3 !== 1'b0) seen = 1'b1;
    end
    compared++; if (seen !== 1'b0) begin mismatched++; $display("FAIL rm_no_done: got activity after reset required none"); end
    fixed_rdata = 16'h5678;
    addr[0] = 16'h0060; we[0] = 1'b0; acc_sz[0] = 1'b1; req3 = 3'b001;
    tick(); tick(); tick();
    compared++; if (done3 !== 3'b000 || busy3 !== 1'b1) begin mismatched++; $display("FAIL rm_lat: got done %b busy %b after 3 cycles required 000/1", done3, busy3); end
    tick();
    compared++; if (done3 !== 3'b001 || rdata3 !== 16'h5678 || mem_acc_sz3 !== 1'b1) begin mismatched++; $display("FAIL rm_next: got done %b rdata %h acc_sz %b required 001/5678/1", done3, rdata3, mem_acc_sz3); end
    req3 = 3'b000;
    tick();
  endtask

  task automatic test_random();
    int          issued [3];
    int          ndone [3];
    logic        pend [3];
    logic [15:0] exp;
    logic [3:0]  a;
    int          cyc;
    logic        finished;
    req = 3'b000; use_model = 1'b1; model_init = 1'b1; reset = 1'b1;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
    for (int i = 0; i < 3; i++) begin issued[i] = 0; ndone[i] = 0; pend[i] = 1'b0; end
    tick();
    model_init = 1'b0; reset = 1'b0;
    cyc = 0; finished = 1'b0;
    while (cyc < 3000 && !finished) begin
      tick();
      cyc++;
      for (int i = 0; i < 3; i++) begin
        if (done[i]) begin
          compared++;
          if (!pend[i]) begin
            mismatched++; $display("FAIL rand_spurious%0d: got done with req low required no done", i);
          end else begin
            a   = addr[i][3:0];
            exp = we[i] ? 16'h0000 : (acc_sz[i] ? ref_mem[a] : {8'h00, ref_mem[a][7:0]});
            compared++;
            if (rdata !== exp) begin mismatched++; $display("FAIL rand_data%0d: got %h required %h (addr %h we %b sz %b)", i, rdata, exp, addr[i], we[i], acc_sz[i]); end
            if (we[i]) ref_mem[a] = wdata[i];
            pend[i] = 1'b0; req[i] = 1'b0; ndone[i]++;
          end
        end else if (!pend[i] && issued[i] < 30 && $urandom_range(0, 3) == 0) begin
          addr[i]   = {12'h000, 4'($urandom_range(0, 15))};
          we[i]     = 1'($urandom_range(0, 1));
          acc_sz[i] = we[i] | 1'($urandom_range(0, 1));
          wdata[i]  = 16'($urandom);
          req[i]    = 1'b1; pend[i] = 1'b1; issued[i]++;
        end
      end
      finished = (issued[0] == 30) && (issued[1] == 30) && (issued[2] == 30) && !pend[0] && !pend[1] && !pend[2];
    end
    compared++; if (!finished) begin mismatched++; $display("FAIL rand_timeout: got unfinished after %0d cycles required completion", cyc); end
    for (int i = 0; i < 3; i++) begin
      compared++; if (ndone[i] !== issued[i]) begin mismatched++; $display("FAIL rand_count%0d: got %0d dones required %0d", i, ndone[i], issued[i]); end
    end
    req = 3'b000; use_model = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; reset3 = 1'b1; req = '0; req3 = '0; addr = '0; wdata = '0; we = '0; acc_sz = '1;
    fixed_rdata = '0; use_model = 1'b0; model_init = 1'b0;
    test_reset();
    test_single_read();
    test_byte_and_write();
    test_round_robin();
    test_dbg_starve();
    test_reset_mid_access();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
